// File: rtl/modbus_scan_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : modbus_scan_scheduler
// Brief    : Walks the scan table once per scan period and hands one poll
//            request per enabled entry to the Modbus master engine. Each
//            response is supervised with a tick-based timeout and bounded
//            retries. Per-entry, per-round and overrun pulses go to CSR/IRQ.
// Revision : 1.0 - initial release
// ============================================================================
module modbus_scan_scheduler #(
    parameter int N_ENTRIES = 16,
    parameter int IDX_W     = 4
) (
    input  logic             PCLK,
    input  logic             PRESET,
    input  logic             tick,
    input  logic             cfg_en,
    input  logic [IDX_W:0]   cfg_num,
    input  logic [15:0]      cfg_period,
    input  logic [15:0]      cfg_timeout,
    input  logic [2:0]       cfg_retries,
    output logic [IDX_W-1:0] tbl_rd_idx,
    input  logic [31:0]      tbl_rd_entry,
    input  logic [15:0]      tbl_rd_qty,
    output logic             req_valid,
    input  logic             req_ready,
    output logic [7:0]       req_slave,
    output logic [7:0]       req_func,
    output logic [15:0]      req_addr,
    output logic [15:0]      req_qty,
    output logic [IDX_W-1:0] req_idx,
    input  logic             rsp_valid,
    input  logic             rsp_err,
    output logic             busy,
    output logic             entry_done,
    output logic [IDX_W-1:0] done_idx,
    output logic             done_ok,
    output logic             round_done,
    output logic             overrun
);

    localparam logic [2:0] c_IDLE        = 3'd0;
    localparam logic [2:0] c_FETCH       = 3'd1;
    localparam logic [2:0] c_LOAD        = 3'd2;
    localparam logic [2:0] c_ISSUE       = 3'd3;
    localparam logic [2:0] c_WAIT_RSP    = 3'd4;
    localparam logic [2:0] c_NEXT        = 3'd5;
    localparam logic [2:0] c_WAIT_PERIOD = 3'd6;

    // Entry count is clamped to the table depth so a bad CSR value cannot
    // walk the read address past the end of the table.
    localparam logic [IDX_W:0] c_N_MAX = N_ENTRIES[IDX_W:0];

    logic [2:0]       r_state;
    logic [2:0]       w_next_state;
    logic [IDX_W-1:0] r_cur_idx;
    logic [2:0]       r_retry_cnt;
    logic [15:0]      r_period_cnt;
    logic [15:0]      r_to_cnt;
    logic [7:0]       r_req_slave;
    logic [7:0]       r_req_func;
    logic [15:0]      r_req_addr;
    logic [15:0]      r_req_qty;
    logic [IDX_W-1:0] r_req_idx;
    logic             r_entry_done;
    logic [IDX_W-1:0] r_done_idx;
    logic             r_done_ok;
    logic             r_round_done;
    logic             r_overrun;

    logic [IDX_W:0]   w_num_eff;
    logic [IDX_W:0]   w_idx_inc;
    logic             w_more;
    logic             w_period_hit;
    logic             w_timeout;
    logic             w_rsp_done;
    logic             w_rsp_fail;
    logic             w_retry;
    logic             w_restart;

    assign w_num_eff    = (cfg_num > c_N_MAX) ? c_N_MAX : cfg_num;
    assign w_idx_inc    = {1'b0, r_cur_idx} + {{IDX_W{1'b0}}, 1'b1};
    assign w_more       = (w_idx_inc < w_num_eff);
    assign w_period_hit = (r_period_cnt >= cfg_period);
    assign w_timeout    = (cfg_timeout != 16'd0) && (r_to_cnt == cfg_timeout);
    // A response strobe outranks a timeout that expires in the same cycle.
    assign w_rsp_done   = rsp_valid || w_timeout;
    assign w_rsp_fail   = rsp_valid ? rsp_err : w_timeout;
    // Retries are suppressed once the scan has been disabled.
    assign w_retry      = w_rsp_fail && (r_retry_cnt < cfg_retries) && cfg_en;
    // Every entry into FETCH except the in-round step to the next entry starts
    // a new round and therefore restarts the period counter.
    assign w_restart    = (w_next_state == c_FETCH) && !((r_state == c_NEXT) && w_more);

    // State register
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE:        if (cfg_en && (w_num_eff != '0)) w_next_state = c_FETCH;
            c_FETCH:       w_next_state = cfg_en ? c_LOAD : c_IDLE;
            c_LOAD: begin
                if (!cfg_en)                   w_next_state = c_IDLE;
                else if (tbl_rd_qty == 16'd0)  w_next_state = c_NEXT;
                else                           w_next_state = c_ISSUE;
            end
            c_ISSUE:       if (req_ready) w_next_state = c_WAIT_RSP;
            c_WAIT_RSP:    if (w_rsp_done) w_next_state = w_retry ? c_ISSUE : c_NEXT;
            c_NEXT: begin
                if (!cfg_en)            w_next_state = c_IDLE;
                else if (w_more)        w_next_state = c_FETCH;
                else if (w_period_hit)  w_next_state = c_FETCH;
                else                    w_next_state = c_WAIT_PERIOD;
            end
            c_WAIT_PERIOD: begin
                if (!cfg_en)            w_next_state = c_IDLE;
                else if (w_period_hit)  w_next_state = c_FETCH;
            end
            default:       w_next_state = c_IDLE;
        endcase
    end

    // Outputs decoded straight from state so reset drops req_valid at once
    always_comb begin
        busy       = (r_state != c_IDLE);
        req_valid  = (r_state == c_ISSUE);
        tbl_rd_idx = r_cur_idx;
    end

    assign req_slave  = r_req_slave;
    assign req_func   = r_req_func;
    assign req_addr   = r_req_addr;
    assign req_qty    = r_req_qty;
    assign req_idx    = r_req_idx;
    assign entry_done = r_entry_done;
    assign done_idx   = r_done_idx;
    assign done_ok    = r_done_ok;
    assign round_done = r_round_done;
    assign overrun    = r_overrun;

    // Datapath: index walk, counters, request capture and status pulses
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            r_cur_idx    <= '0;
            r_retry_cnt  <= '0;
            r_period_cnt <= '0;
            r_to_cnt     <= '0;
            r_req_slave  <= '0;
            r_req_func   <= '0;
            r_req_addr   <= '0;
            r_req_qty    <= '0;
            r_req_idx    <= '0;
            r_entry_done <= 1'b0;
            r_done_idx   <= '0;
            r_done_ok    <= 1'b0;
            r_round_done <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_entry_done <= 1'b0;
            r_round_done <= 1'b0;
            r_overrun    <= 1'b0;

            if (w_restart) begin
                r_period_cnt <= '0;
            end else if ((r_state != c_IDLE) && tick && (r_period_cnt != 16'hFFFF)) begin
                r_period_cnt <= r_period_cnt + 16'd1;
            end

            case (r_state)
                c_IDLE: r_cur_idx <= '0;
                c_LOAD: begin
                    r_req_slave <= tbl_rd_entry[31:24];
                    r_req_func  <= tbl_rd_entry[23:16];
                    r_req_addr  <= tbl_rd_entry[15:0];
                    r_req_qty   <= tbl_rd_qty;
                    r_req_idx   <= r_cur_idx;
                    r_retry_cnt <= '0;
                end
                c_ISSUE: if (req_ready) r_to_cnt <= '0;
                c_WAIT_RSP: begin
                    if (w_rsp_done) begin
                        if (w_retry) begin
                            r_retry_cnt <= r_retry_cnt + 3'd1;
                        end else begin
                            r_entry_done <= 1'b1;
                            r_done_idx   <= r_req_idx;
                            r_done_ok    <= !w_rsp_fail;
                        end
                    end else if (tick && (r_to_cnt != 16'hFFFF)) begin
                        r_to_cnt <= r_to_cnt + 16'd1;
                    end
                end
                c_NEXT: begin
                    if (cfg_en) begin
                        if (w_more) begin
                            r_cur_idx <= w_idx_inc[IDX_W-1:0];
                        end else begin
                            r_cur_idx    <= '0;
                            r_round_done <= 1'b1;
                            r_overrun    <= w_period_hit && (cfg_period != 16'd0) &&
                                            (r_period_cnt > cfg_period);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_modbus_scan_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_modbus_scan_scheduler
// Brief    : Self-checking bench for modbus_scan_scheduler. A transaction
//            model predicts the request stream and entry outcomes from the
//            scan table, configuration and planned engine behaviour.
// Revision : 1.0 - initial release
// ============================================================================
module tb_modbus_scan_scheduler;

    localparam int IDX_W = 4;

    logic             PCLK = 1'b0;
    logic             PRESET = 1'b1;
    logic             tick = 1'b0;
    logic             cfg_en = 1'b0;
    logic [IDX_W:0]   cfg_num = '0;
    logic [15:0]      cfg_period = '0;
    logic [15:0]      cfg_timeout = '0;
    logic [2:0]       cfg_retries = '0;
    logic [IDX_W-1:0] tbl_rd_idx;
    logic [31:0]      tbl_rd_entry = '0;
    logic [15:0]      tbl_rd_qty = '0;
    logic             req_valid;
    logic             req_ready = 1'b1;
    logic [7:0]       req_slave;
    logic [7:0]       req_func;
    logic [15:0]      req_addr;
    logic [15:0]      req_qty;
    logic [IDX_W-1:0] req_idx;
    logic             rsp_valid = 1'b0;
    logic             rsp_err = 1'b0;
    logic             busy;
    logic             entry_done;
    logic [IDX_W-1:0] done_idx;
    logic             done_ok;
    logic             round_done;
    logic             overrun;

    modbus_scan_scheduler #(.N_ENTRIES(16), .IDX_W(IDX_W)) dut (
        .PCLK(PCLK), .PRESET(PRESET), .tick(tick), .cfg_en(cfg_en),
        .cfg_num(cfg_num), .cfg_period(cfg_period), .cfg_timeout(cfg_timeout),
        .cfg_retries(cfg_retries), .tbl_rd_idx(tbl_rd_idx),
        .tbl_rd_entry(tbl_rd_entry), .tbl_rd_qty(tbl_rd_qty),
        .req_valid(req_valid), .req_ready(req_ready), .req_slave(req_slave),
        .req_func(req_func), .req_addr(req_addr), .req_qty(req_qty),
        .req_idx(req_idx), .rsp_valid(rsp_valid), .rsp_err(rsp_err),
        .busy(busy), .entry_done(entry_done), .done_idx(done_idx),
        .done_ok(done_ok), .round_done(round_done), .overrun(overrun)
    );

    always #5 PCLK = ~PCLK;

    // Scan-table RAM: registered read, data valid one cycle after address
    logic [31:0] mem_entry [16];
    logic [15:0] mem_qty   [16];
    always @(posedge PCLK) begin
        tbl_rd_entry <= mem_entry[tbl_rd_idx];
        tbl_rd_qty   <= mem_qty[tbl_rd_idx];
    end

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int tick_cnt = 0;
    int round_cnt = 0;
    int ovr_cnt = 0;
    int rd_cyc = 0;
    int stab_bad = 0;
    int rdy_mode = 0;   // 0: always ready, 1: random, 2: never ready

    logic [51:0] got_req[$];
    int          got_tick[$];
    int          got_cyc[$];
    logic [4:0]  got_done[$];
    logic [51:0] exp_req[$];
    logic [4:0]  exp_done[$];
    int          plan_kind[$];   // 0 ok, 1 err, 2 silent, 3 err on timeout cycle
    int          plan_dly[$];

    function automatic logic [51:0] pack_req(input int idx);
        return {4'(idx), mem_entry[idx], mem_qty[idx]};
    endfunction

    // Engine model: ready, responses, ticks and event logging, all on negedge
    initial begin : engine
        int cd, age, kind, dly;
        bit hold;
        logic [51:0] held, cur;
        cd = 0; age = 0; kind = 0; dly = 0; hold = 1'b0; held = '0;
        forever begin
            @(negedge PCLK);
            cyc++;
            rsp_valid = 1'b0;
            rsp_err   = 1'b0;
            if (PRESET) begin
                cd = 0; age = 0; hold = 1'b0; tick = 1'b0;
                continue;
            end
            if (cd > 0) begin
                cd--;
                if (cd == 0) begin rsp_valid = 1'b1; rsp_err = (kind == 1); end
            end
            if (age > 0) begin
                age++;
                if (age >= 3 && tick) begin rsp_valid = 1'b1; rsp_err = 1'b1; age = 0; end
            end
            tick = (cyc % 4 == 0);
            if (tick) tick_cnt++;
            case (rdy_mode)
                0:       req_ready = 1'b1;
                1:       req_ready = ($urandom_range(0, 3) != 0);
                default: req_ready = 1'b0;
            endcase
            cur = {req_idx, req_slave, req_func, req_addr, req_qty};
            if (hold && (!req_valid || cur != held)) stab_bad++;
            if (req_valid && req_ready) begin
                got_req.push_back(cur);
                got_tick.push_back(tick_cnt);
                got_cyc.push_back(cyc);
                if (plan_kind.size() > 0) begin
                    kind = plan_kind.pop_front();
                    dly  = plan_dly.pop_front();
                end else begin
                    kind = 0; dly = 1;
                end
                if (kind == 3) age = 1;
                else if (kind != 2) cd = dly;
                hold = 1'b0;
            end else begin
                hold = req_valid;
                held = cur;
            end
            if (entry_done) got_done.push_back({done_idx, done_ok});
            if (round_done) begin round_cnt++; rd_cyc = cyc; end
            if (overrun) ovr_cnt++;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_rng(input string tag, input int obs, input int lo, input int hi);
        total++;
        assert (obs >= lo && obs <= hi) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
        end
    endtask

    task automatic exp_try(input int idx, input int kind, input int dly);
        exp_req.push_back(pack_req(idx));
        plan_kind.push_back(kind);
        plan_dly.push_back(dly);
    endtask

    task automatic exp_fin(input int idx, input bit ok);
        exp_done.push_back({4'(idx), ok});
    endtask

    // Reference model of one round: enabled entries in index order, each
    // attempted until success or until the retry budget is spent.
    task automatic model_round(input int num, input int retries);
        int r, kind;
        bit ok;
        for (int e = 0; e < num; e++) begin
            if (mem_qty[e] == 16'd0) continue;
            ok = 1'b0;
            for (int a = 0; a <= retries; a++) begin
                r = $urandom_range(0, 3);
                kind = (r == 0) ? 1 : (r == 1) ? 2 : 0;
                exp_try(e, kind, $urandom_range(1, 3));
                if (kind == 0) begin ok = 1'b1; break; end
            end
            exp_fin(e, ok);
        end
    endtask

    task automatic wait_reqs(input string tag, input int n, input int budget);
        int k = 0;
        while (got_req.size() < n && k < budget) begin @(negedge PCLK); k++; end
        chk_rng(tag, got_req.size(), n, 64);
    endtask

    task automatic stop_scan(input string tag);
        int k = 0;
        cfg_en = 1'b0;
        while (busy !== 1'b0 && k < 3000) begin @(negedge PCLK); k++; end
        repeat (2) @(negedge PCLK);
        chk({tag, "_idle"}, busy, 0);
    endtask

    task automatic compare_logs(input string tag);
        chk({tag, "_nreq"}, got_req.size(), exp_req.size());
        chk({tag, "_ndone"}, got_done.size(), exp_done.size());
        for (int i = 0; i < exp_req.size() && i < got_req.size(); i++)
            chk($sformatf("%s_req%0d", tag, i), got_req[i], exp_req[i]);
        for (int i = 0; i < exp_done.size() && i < got_done.size(); i++)
            chk($sformatf("%s_done%0d", tag, i), got_done[i], exp_done[i]);
        chk({tag, "_stable"}, stab_bad, 0);
        got_req.delete(); got_tick.delete(); got_cyc.delete(); got_done.delete();
        exp_req.delete(); exp_done.delete(); plan_kind.delete(); plan_dly.delete();
    endtask

    task automatic run_round(input string tag);
        int start, k;
        start = round_cnt; k = 0;
        cfg_en = 1'b1;
        while (round_cnt == start && k < 20000) begin @(negedge PCLK); k++; end
        chk({tag, "_rounds"}, round_cnt - start, 1);
        stop_scan(tag);
        compare_logs(tag);
    endtask

    initial begin : stim
        int start, ostart, k;
        for (int i = 0; i < 16; i++) begin mem_entry[i] = '0; mem_qty[i] = '0; end

        // Reset state
        repeat (3) @(negedge PCLK);
        chk("rst_busy", busy, 0);
        chk("rst_req_valid", req_valid, 0);
        chk("rst_pulses", {entry_done, round_done, overrun, done_ok}, 0);
        chk("rst_idx", {tbl_rd_idx, req_idx, done_idx}, 0);
        chk("rst_req_fields", {req_slave, req_func, req_addr, req_qty}, 0);
        PRESET = 1'b0;
        repeat (2) @(negedge PCLK);

        // Two entries back-to-back, round restarts with no period gap
        mem_entry[0] = {8'h01, 8'h03, 16'h0000}; mem_qty[0] = 16'd4;
        mem_entry[1] = {8'h02, 8'h04, 16'h0010}; mem_qty[1] = 16'd2;
        cfg_num = 5'd2; cfg_period = 16'd0; cfg_timeout = 16'd0; cfg_retries = 3'd0;
        exp_try(0, 0, 5); exp_fin(0, 1'b1);
        exp_try(1, 0, 5); exp_fin(1, 1'b1);
        exp_try(0, 0, 5); exp_fin(0, 1'b1);
        start = round_cnt;
        cfg_en = 1'b1;
        wait_reqs("b2b_reqs", 3, 500);
        chk("b2b_rounds", round_cnt - start, 1);
        if (got_cyc.size() >= 3) chk_rng("b2b_gap", got_cyc[2] - rd_cyc, 1, 3);
        stop_scan("b2b");
        compare_logs("b2b");

        // Disabled entry (qty 0) is skipped silently
        mem_entry[0] = {8'h11, 8'h03, 16'h0020}; mem_qty[0] = 16'd3;
        mem_qty[1] = 16'd0;
        mem_entry[2] = {8'h13, 8'h06, 16'h0100}; mem_qty[2] = 16'd1;
        cfg_num = 5'd3; cfg_period = 16'hFFFF;
        exp_try(0, 0, 2); exp_fin(0, 1'b1);
        exp_try(2, 0, 2); exp_fin(2, 1'b1);
        run_round("skip");

        // Silent slave: timeout after 3 ticks, two retries, then failure
        cfg_num = 5'd1; cfg_timeout = 16'd3; cfg_retries = 3'd2;
        for (int i = 0; i < 3; i++) exp_try(0, 2, 1);
        exp_fin(0, 1'b0);
        start = round_cnt;
        cfg_en = 1'b1;
        wait_reqs("tmo_reqs", 3, 500);
        if (got_tick.size() >= 3) begin
            chk_rng("tmo_ticks_1", got_tick[1] - got_tick[0], 3, 4);
            chk_rng("tmo_ticks_2", got_tick[2] - got_tick[1], 3, 4);
        end
        k = 0;
        while (round_cnt == start && k < 500) begin @(negedge PCLK); k++; end
        stop_scan("tmo");
        compare_logs("tmo");

        // Error response on the very cycle the timeout expires: one failure
        cfg_timeout = 16'd1; cfg_retries = 3'd0;
        exp_try(0, 3, 1); exp_fin(0, 1'b0);
        run_round("collide");

        // Period 100 ticks: idle in between, restart after the full period
        mem_entry[1] = {8'h02, 8'h04, 16'h0010}; mem_qty[1] = 16'd2;
        cfg_num = 5'd2; cfg_timeout = 16'd0; cfg_period = 16'd100;
        exp_try(0, 0, 2); exp_fin(0, 1'b1);
        exp_try(1, 0, 2); exp_fin(1, 1'b1);
        exp_try(0, 0, 2); exp_fin(0, 1'b1);
        ostart = ovr_cnt;
        cfg_en = 1'b1;
        wait_reqs("per_reqs", 3, 1500);
        if (got_tick.size() >= 3) chk_rng("per_ticks", got_tick[2] - got_tick[0], 99, 102);
        stop_scan("per");
        chk("per_no_overrun", ovr_cnt - ostart, 0);
        compare_logs("per");

        // Round longer than the period: overrun, next round immediately
        cfg_num = 5'd1; cfg_period = 16'd20; cfg_timeout = 16'd30;
        exp_try(0, 2, 1); exp_fin(0, 1'b0);
        exp_try(0, 2, 1); exp_fin(0, 1'b0);
        ostart = ovr_cnt;
        cfg_en = 1'b1;
        wait_reqs("ovr_reqs", 2, 1500);
        if (got_cyc.size() >= 2) chk_rng("ovr_gap", got_cyc[1] - rd_cyc, 1, 3);
        stop_scan("ovr");
        chk("ovr_pulses", ovr_cnt - ostart, 1);
        compare_logs("ovr");

        // Backpressure holds the request; disable during WAIT_RSP finishes it
        cfg_timeout = 16'd0; cfg_period = 16'hFFFF;
        exp_try(0, 0, 3); exp_fin(0, 1'b1);
        start = round_cnt;
        rdy_mode = 2;
        cfg_en = 1'b1;
        repeat (12) @(negedge PCLK);
        chk("bp_valid", req_valid, 1);
        chk("bp_none_taken", got_req.size(), 0);
        chk("bp_fields", {req_idx, req_slave, req_func, req_addr, req_qty}, pack_req(0));
        rdy_mode = 0;
        wait_reqs("bp_accept", 1, 50);
        @(negedge PCLK);
        stop_scan("bp");
        chk("bp_no_round", round_cnt - start, 0);
        compare_logs("bp");

        // Asynchronous reset while a request is outstanding
        rdy_mode = 2;
        cfg_en = 1'b1;
        k = 0;
        while (req_valid !== 1'b1 && k < 50) begin @(negedge PCLK); k++; end
        chk("prst_valid_before", req_valid, 1);
        #2 PRESET = 1'b1;
        #1;
        chk("prst_valid_drop", req_valid, 0);
        chk("prst_busy", busy, 0);
        @(negedge PCLK);
        cfg_en = 1'b0; rdy_mode = 0;
        @(negedge PCLK);
        PRESET = 1'b0;
        repeat (2) @(negedge PCLK);
        compare_logs("prst");

        // Randomized tables, retry budgets, timeouts and engine behaviour
        rdy_mode = 1;
        for (int t = 0; t < 6; t++) begin
            int num, rtr;
            num = $urandom_range(1, 8);
            rtr = $urandom_range(0, 3);
            for (int e = 0; e < num; e++) begin
                mem_entry[e] = $urandom;
                mem_qty[e] = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom_range(1, 125));
            end
            cfg_num = 5'(num);
            cfg_retries = 3'(rtr);
            cfg_timeout = 16'($urandom_range(2, 5));
            cfg_period = 16'hFFFF;
            model_round(num, rtr);
            run_round($sformatf("rnd%0d", t));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
